// File: rtl/cache_memtest.sv
// Cache memory tester: writes an address-XOR-seed pattern to WORD_COUNT words,
// reads them back, counts mismatches, and reports pass/timeout at the end.
module cache_memtest #(
  parameter int unsigned WORD_COUNT     = 1024,
  parameter logic [31:0] BASE_ADDRESS   = 32'h0000_0000,
  parameter logic [31:0] SEED           = 32'hA5A5_5A5A,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] address,
  output logic [31:0] data_in,
  output logic [3:0]  write_enable,
  input  logic [31:0] data_out,
  input  logic        data_out_ready,
  input  logic        busy,
  output logic        running,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] error_count,
  output logic [31:0] first_error_address,
  output logic [31:0] first_error_data
);

  localparam int          IW   = 21;
  localparam logic [IW-1:0] LAST = IW'(WORD_COUNT - 1);
  // Last stall cycle index before the access is declared timed out.
  localparam logic [31:0] TMAX = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, WR_ISSUE, WR_GAP, RD_ISSUE, RD_GAP, DONE} state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic [31:0]   wcnt;

  assign idx_nxt = idx + IW'(1);

  function automatic logic [31:0] word_addr(input logic [IW-1:0] i);
    return BASE_ADDRESS + (32'(i) << 2);
  endfunction

  // Single FSM: sequences the write pass then the read pass; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      idx                 <= '0;
      wcnt                <= '0;
      address             <= '0;
      data_in             <= '0;
      write_enable        <= '0;
      running             <= 1'b0;
      done                <= 1'b0;
      pass                <= 1'b0;
      timeout             <= 1'b0;
      error_count         <= '0;
      first_error_address <= '0;
      first_error_data    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx                 <= '0;
            wcnt                <= '0;
            error_count         <= '0;
            first_error_address <= '0;
            first_error_data    <= '0;
            pass                <= 1'b0;
            timeout             <= 1'b0;
            done                <= 1'b0;
            running             <= 1'b1;
            address             <= word_addr('0);
            data_in             <= word_addr('0) ^ SEED;
            write_enable        <= 4'hF;
            state               <= WR_ISSUE;
          end
        end
        WR_ISSUE: begin
          if (!busy) begin
            write_enable <= 4'h0;
            state        <= WR_GAP;
          end else if (wcnt == TMAX) begin
            // Abandon the run: the cache never accepted this write.
            write_enable <= 4'h0;
            timeout      <= 1'b1;
            pass         <= 1'b0;
            done         <= 1'b1;
            running      <= 1'b0;
            state        <= DONE;
          end else begin
            wcnt <= wcnt + 32'd1;
          end
        end
        WR_GAP: begin
          wcnt <= '0;
          if (idx == LAST) begin
            idx     <= '0;
            address <= word_addr('0);
            data_in <= '0;
            state   <= RD_ISSUE;
          end else begin
            idx          <= idx_nxt;
            address      <= word_addr(idx_nxt);
            data_in      <= word_addr(idx_nxt) ^ SEED;
            write_enable <= 4'hF;
            state        <= WR_ISSUE;
          end
        end
        RD_ISSUE: begin
          if (!busy && data_out_ready) begin
            if (data_out != (word_addr(idx) ^ SEED)) begin
              if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
              // A zero count means this is the first mismatch of the run.
              if (error_count == 16'd0) begin
                first_error_address <= address;
                first_error_data    <= data_out;
              end
            end
            state <= RD_GAP;
          end else if (wcnt == TMAX) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
            done    <= 1'b1;
            running <= 1'b0;
            state   <= DONE;
          end else begin
            wcnt <= wcnt + 32'd1;
          end
        end
        RD_GAP: begin
          wcnt <= '0;
          if (idx == LAST) begin
            done    <= 1'b1;
            running <= 1'b0;
            pass    <= (error_count == 16'd0) && !timeout;
            state   <= DONE;
          end else begin
            idx     <= idx_nxt;
            address <= word_addr(idx_nxt);
            state   <= RD_ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cache_memtest.md
CACHE_MEMTEST -- requirements
Module: cache_memtest

Interface
REQ-001 SHALL have parameter WORD_COUNT, default 1024, meaning 32-bit words tested, range 1..2^20.
REQ-002 SHALL have parameter BASE_ADDRESS, default 0, meaning byte address of the first word, 4-byte aligned.
REQ-003 SHALL have parameter SEED, default 32'hA5A5_5A5A, meaning XOR seed for the data pattern.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the maximum cycles one access may wait.
REQ-005 SHALL have port clk  input  1  the only clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  one-cycle pulse that begins a test run.
REQ-008 SHALL have port address  output  32  byte address to the cache.
REQ-009 SHALL have port data_in  output  32  write data to the cache.
REQ-010 SHALL have port write_enable  output  4  byte enables; 4'b1111 for a write, 0 otherwise.
REQ-011 SHALL have port data_out  input  32  read data from the cache.
REQ-012 SHALL have port data_out_ready  input  1  data_out is valid for the current address.
REQ-013 SHALL have port busy  input  1  the cache is not accepting a new access.
REQ-014 SHALL have port running  output  1  a test run is in progress.
REQ-015 SHALL have port done  output  1  the run has finished; held until the next start or reset.
REQ-016 SHALL have port pass  output  1  valid with done; 1 means zero mismatches and no timeout.
REQ-017 SHALL have port timeout  output  1  valid with done; 1 means an access exceeded TIMEOUT_CYCLES.
REQ-018 SHALL have port error_count  output  16  mismatch count, saturating at 16'hFFFF.
REQ-019 SHALL have port first_error_address  output  32  address of the first mismatch.
REQ-020 SHALL have port first_error_data  output  32  data_out at the first mismatch.

Function
REQ-021 SHALL implement the FSM states IDLE, WR_ISSUE, WR_GAP, RD_ISSUE, RD_GAP and DONE.
REQ-022 SHALL define word i to be at address BASE_ADDRESS + 4*i, with expected data (BASE_ADDRESS + 4*i) ^ SEED, computed modulo 2^32.
REQ-023 SHALL, in IDLE or DONE, on start=1: clear the index, error_count, first_error_*, pass and timeout; enter WR_ISSUE; and raise running the next cycle.
REQ-024 SHALL, in WR_ISSUE, drive the address, the pattern on data_in and write_enable=4'b1111.
REQ-025 SHALL treat a write as accepted at the first rising edge in WR_ISSUE with busy=0, then move to WR_GAP.
REQ-026 SHALL, in WR_GAP, drive write_enable=0 for exactly one cycle and increment the index.
REQ-027 SHALL make WR_GAP go to RD_ISSUE with index=0 if the last word was written, otherwise to WR_ISSUE.
REQ-028 SHALL, in RD_ISSUE, drive the address with write_enable=0 and data_in=0.
REQ-029 SHALL sample a read at the first rising edge in RD_ISSUE with busy=0 and data_out_ready=1, then move to RD_GAP.
REQ-030 SHALL, on a sampled read where data_out differs from the expected data, increment error_count with saturation.
REQ-031 SHALL, on the first mismatch only, latch first_error_address and first_error_data.
REQ-032 SHALL make RD_GAP last one cycle and increment the index, going to DONE after the last word, otherwise to RD_ISSUE.
REQ-033 SHALL, in DONE, assert done=1 and running=0, and set pass = (error_count==0 && !timeout).
REQ-034 SHALL keep a per-access wait counter that clears on entry to WR_ISSUE or RD_ISSUE.
REQ-035 SHALL, when the wait counter reaches TIMEOUT_CYCLES, set timeout=1 and go to DONE without completing the remaining accesses.
REQ-036 SHALL ignore start while running=1.
REQ-037 SHALL make WORD_COUNT=1 perform exactly one write and one read.
REQ-038 SHALL produce exactly 2*WORD_COUNT write_enable-active cycle groups and reads, with zero wait states per access beyond busy.

Reset
REQ-039 SHALL, on rst=1 at a rising edge, enter IDLE with all outputs 0.
REQ-040 SHALL, on rst=1 mid-run, abort the run at that edge with no further write_enable assertion, and require a new start.

Verification
REQ-041 SHALL be verified with an ideal cache model (busy=0, data_out_ready=1, zero latency) and WORD_COUNT=4: writes to 0,4,8,12 with data 0xA5A55A5A, 0xA5A55A5E, 0xA5A55A52, 0xA5A55A56, then 4 reads -> done=1, pass=1, error_count=0.
REQ-042 SHALL be verified with a model forcing data_out bit 0 inverted at address 8, WORD_COUNT=4 -> error_count=1, first_error_address=8, first_error_data=0xA5A55A53, pass=0.
REQ-043 SHALL be verified with busy held at 1 after the 2nd write and TIMEOUT_CYCLES=16 -> done=1, timeout=1, pass=0 within 16+3 cycles of the stall.
REQ-044 SHALL be verified with a cache model of random busy (1..8 cycles) and data_out_ready latency, WORD_COUNT=64 -> pass=1 and every write_enable pulse paired with the correct address/data.
REQ-045 SHALL be verified with rst asserted during the read phase, then start reissued -> outputs zero after reset and the second run passes from index 0.
REQ-046 SHALL be verified with start pulsed again while running -> no restart, and the final counts are unchanged versus a single start.
